// File: rtl/reg_file_access_ctrl_pkg.sv
// Shared types and default widths for the register-file access controller.
package reg_file_access_ctrl_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WRITE     = 3'd1,
    ST_READ      = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/reg_file_access_ctrl.sv
// Single-command register-file access controller: accepts one read/write command,
// drives a one-cycle strobe to the register file, and holds the response until accepted.
module reg_file_access_ctrl
  import reg_file_access_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              Wr_Enable,
  output logic              Rd_Enable,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Wr_Data,
  input  logic [DATA_W-1:0] Rd_Data,
  output logic [7:0]        txn_count
);

  state_t state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      Wr_Enable <= 1'b0;
      Rd_Enable <= 1'b0;
      Address   <= '0;
      Wr_Data   <= '0;
      txn_count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Command fields are captured here; upstream may change them afterwards.
            cmd_ready <= 1'b0;
            Address   <= cmd_addr;
            Wr_Data   <= cmd_wdata;
            if (cmd_write) begin
              state     <= ST_WRITE;
              Wr_Enable <= 1'b1;
            end else begin
              state     <= ST_READ;
              Rd_Enable <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          state     <= ST_RESP;
          Wr_Enable <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_write <= 1'b1;
          rsp_rdata <= '0;
        end

        ST_READ: begin
          state     <= ST_READ_WAIT;
          Rd_Enable <= 1'b0;
        end

        // Register file presents read data one edge after the strobe.
        ST_READ_WAIT: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_write <= 1'b0;
          rsp_rdata <= Rd_Data;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            txn_count <= txn_count + 8'd1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          Wr_Enable <= 1'b0;
          Rd_Enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_access_ctrl.sv
// Directed bench for reg_file_access_ctrl with a small behavioural register file attached.
module tb_reg_file_access_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 2;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              Wr_Enable;
  logic              Rd_Enable;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Wr_Data;
  logic [DATA_W-1:0] Rd_Data = '0;
  logic [7:0]        txn_count;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  logic [DATA_W-1:0] rf [4];

  reg_file_access_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .Wr_Enable(Wr_Enable), .Rd_Enable(Rd_Enable), .Address(Address),
    .Wr_Data(Wr_Data), .Rd_Data(Rd_Data), .txn_count(txn_count)
  );

  always #5 CLK = ~CLK;

  // Register file: write on strobe, registered read data on strobe.
  initial for (int k = 0; k < 4; k++) rf[k] = '0;
  always @(posedge CLK) begin
    if (Wr_Enable) rf[Address] <= Wr_Data;
    if (Rd_Enable) Rd_Data <= rf[Address];
  end

  always @(negedge CLK) if (Wr_Enable && Rd_Enable) overlap++;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_write"}, rsp_write, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_wr_en"},     Wr_Enable, 0);
    chk({tag, "_rd_en"},     Rd_Enable, 0);
    chk({tag, "_address"},   Address, 0);
    chk({tag, "_wr_data"},   Wr_Data, 0);
    chk({tag, "_txn_count"}, txn_count, 0);
  endtask

  // One full transaction with rsp_ready=1; called right after an edge, in IDLE.
  task automatic do_txn(input logic wr, input logic [1:0] addr, input logic [15:0] wd,
                        input logic [15:0] exp_rd, input logic [7:0] exp_cnt);
    chk("idle_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wd; cmd_write = ~wr;
    chk("strobe_cmd_ready", cmd_ready, 0);
    chk("strobe_rsp_valid", rsp_valid, 0);
    chk("strobe_wr_en", Wr_Enable, wr);
    chk("strobe_rd_en", Rd_Enable, !wr);
    chk("strobe_address", Address, addr);
    if (wr) chk("strobe_wr_data", Wr_Data, wd);
    if (!wr) begin
      tick();
      chk("rwait_rd_en", Rd_Enable, 0);
      chk("rwait_wr_en", Wr_Enable, 0);
      chk("rwait_rsp_valid", rsp_valid, 0);
    end
    tick();
    chk("resp_valid", rsp_valid, 1);
    chk("resp_write", rsp_write, wr);
    chk("resp_rdata", rsp_rdata, wr ? 16'h0000 : exp_rd);
    chk("resp_wr_en", Wr_Enable, 0);
    chk("resp_rd_en", Rd_Enable, 0);
    tick();
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
    chk("done_txn_count", txn_count, exp_cnt);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 2'd1, 16'h00AB, 16'h0000, 8'd1};
    vecs[1] = '{1'b1, 2'd2, 16'h1234, 16'h0000, 8'd2};
    vecs[2] = '{1'b0, 2'd2, 16'h0000, 16'h1234, 8'd3};
    vecs[3] = '{1'b1, 2'd0, 16'hFFFF, 16'h0000, 8'd4};
    vecs[4] = '{1'b1, 2'd3, 16'h8001, 16'h0000, 8'd5};
    vecs[5] = '{1'b0, 2'd0, 16'h0000, 16'hFFFF, 8'd6};
    vecs[6] = '{1'b0, 2'd3, 16'h0000, 16'h8001, 8'd7};
    vecs[7] = '{1'b0, 2'd1, 16'h0000, 16'h00AB, 8'd8};
    vecs[8] = '{1'b1, 2'd1, 16'h0000, 16'h0000, 8'd9};
    vecs[9] = '{1'b0, 2'd1, 16'h0000, 16'h0000, 8'd10};

    // Reset values while RST is held low
    #2 RST = 1'b0;
    #5 chk_reset_vals("rst");
    #5 RST = 1'b1;
    tick();
    chk("post_rst_rsp_valid", rsp_valid, 0);

    for (int i = 0; i < 10; i++)
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_cnt);

    // Read of addr 2 stalled by rsp_ready=0 while a write is offered upstream
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2; cmd_wdata = 16'h0000; rsp_ready = 1'b0;
    tick();
    cmd_write = 1'b1; cmd_addr = 2'd2; cmd_wdata = 16'hDEAD;
    chk("stall_rd_en", Rd_Enable, 1);
    tick();
    tick();
    chk("stall_resp_valid", rsp_valid, 1);
    chk("stall_resp_rdata", rsp_rdata, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold_valid", rsp_valid, 1);
      chk("stall_hold_rdata", rsp_rdata, 16'h1234);
      chk("stall_hold_write", rsp_write, 0);
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_no_wr_en", Wr_Enable, 0);
      chk("stall_txn_count", txn_count, 10);
    end
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("stall_release_valid", rsp_valid, 0);
    chk("stall_release_ready", cmd_ready, 1);
    chk("stall_release_txn", txn_count, 11);
    chk("stall_release_wr_en", Wr_Enable, 0);
    tick();
    chk("stall_not_accepted", Wr_Enable, 0);
    chk("stall_rf2_kept", rf[2], 16'h1234);

    // Reset while the read strobe is active
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd3; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("abort_rd_en", Rd_Enable, 1);
    RST = 1'b0;
    #1 chk_reset_vals("abort");
    tick();
    tick();
    chk("abort_hold_rsp_valid", rsp_valid, 0);
    #2 RST = 1'b1;
    tick();
    chk("abort_after_rsp_valid", rsp_valid, 0);
    chk("abort_after_cmd_ready", cmd_ready, 1);
    tick();
    chk("abort_after2_rsp_valid", rsp_valid, 0);
    chk("abort_after2_txn", txn_count, 0);
    do_txn(1'b1, 2'd0, 16'h5A5A, 16'h0000, 8'd1);
    do_txn(1'b0, 2'd0, 16'h0000, 16'h5A5A, 8'd2);

    // 256 back-to-back writes from a fresh reset wrap the counter
    RST = 1'b0;
    #2 RST = 1'b1;
    chk("wrap_start_txn", txn_count, 0);
    for (int i = 0; i < 256; i++) begin
      do_txn(1'b1, i[1:0], i[15:0], 16'h0000, 8'(i + 1));
      if (i == 254) chk("wrap_txn_255", txn_count, 255);
    end
    chk("wrap_txn_zero", txn_count, 0);
    chk("strobe_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
